// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg -- shared types and constants for the counter_sched block.
//
// Contents:
//   state_e        scheduler FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_NREQ   default requester count used by the top level
//   ptr_reset()    round-robin pointer value loaded at reset; NREQ-1 makes
//                  the first search start at index 0
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_NREQ = 4;

  // The pointer names the last winner; the search begins one past it.
  function automatic int ptr_reset(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/counter_sched_rr_pick.sv
// rr_pick -- purely combinational round-robin selector.
//
// Ports:
//   req_i     [NREQ-1:0]  request levels
//   ptr_i     [IDXW-1:0]  index of the previous winner
//   onehot_o  [NREQ-1:0]  one-hot winner (zero when valid_o is low)
//   idx_o     [IDXW-1:0]  winner index (zero when valid_o is low)
//   valid_o               at least one request is pending
//
// The search visits ptr_i+1, ptr_i+2, ... wrapping modulo NREQ, so the
// previous winner is checked last.
module rr_pick
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int  cand;
    logic found;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = IDXW'(cand);
        onehot_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/counter_sched.sv
// counter_sched -- round-robin scheduler sharing one interval counter
// between NREQ requesters.
//
// Ports:
//   clock     sole clock, rising edge
//   reset     synchronous, active-high
//   req       [NREQ-1:0]       per-requester request level
//   len       [NREQ*SIZE-1:0]  per-requester interval, slice i = len[i*SIZE +: SIZE]
//                              (0 means 2^SIZE ticks)
//   clockinh  freezes the running count while high
//   grant     [NREQ-1:0]  one-hot current owner of the counter
//   busy      high while the FSM is in RUN
//   count     [SIZE-1:0]  current counter value
//   done      [NREQ-1:0]  one-cycle completion pulse to the owner
//   aborted   one-cycle pulse when the owner drops req mid-job
//
// Handshake: a requester holds req high until it sees its done pulse; the
// job's len is captured only on the arbitration edge.
//
// Configuration macro COUNTER_SCHED_ABORT_EN: when defined, a drop of the
// owner's req during RUN abandons the job and pulses aborted. When not
// defined, aborted is constant 0 and req drops during RUN are ignored.
//
// All outputs come straight from registers.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] len,
  input  logic                 clockinh,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [SIZE-1:0]      count,
  output logic [NREQ-1:0]      done,
  output logic                 aborted
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [SIZE-1:0] term_q;
  logic [SIZE-1:0] count_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;

  logic [NREQ-1:0] pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;

  logic [SIZE-1:0] len_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len[g*SIZE +: SIZE];
  end

  rr_pick #(
    .NREQ(NREQ),
    .IDXW(IDXW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Terminal value is term-1 in SIZE-bit arithmetic, so term=0 wraps to
  // all-ones and yields the full 2^SIZE-tick interval.
  logic last_tick;
  assign last_tick = (count_q == (term_q - SIZE'(1)));

`ifdef COUNTER_SCHED_ABORT_EN
  logic aborted_q;
  logic owner_dropped;
  assign owner_dropped = ((req & grant_q) == '0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDXW'(ptr_reset(NREQ));
      term_q  <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef COUNTER_SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_onehot;
            ptr_q   <= pick_idx;
            term_q  <= len_arr[pick_idx];
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
          // Abort outranks both inhibit and completion.
          if (owner_dropped) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else
`endif
          if (!clockinh) begin
            if (last_tick) begin
              done_q  <= grant_q;
              grant_q <= '0;
              busy_q  <= 1'b0;
              count_q <= '0;
              state_q <= DONE;
            end else begin
              count_q <= count_q + SIZE'(1);
            end
          end
        end
        DONE: begin
          // One dead cycle; arbitration resumes on the following IDLE edge.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;

`ifdef COUNTER_SCHED_ABORT_EN
  assign aborted = aborted_q;
`else
  assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched -- directed, table-driven bench for counter_sched
// (NREQ=4, SIZE=8), with hand-written sequences for the long and
// multi-cycle corner cases.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int SIZE = 8;

  logic                 clock;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] len;
  logic                 clockinh;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [SIZE-1:0]      count;
  logic [NREQ-1:0]      done;
  logic                 aborted;

  int checks;
  int errors;

  counter_sched #(
    .NREQ(NREQ),
    .SIZE(SIZE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .len      (len),
    .clockinh (clockinh),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done),
    .aborted  (aborted)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ*SIZE-1:0] pack_len(input logic [7:0] l0, input logic [7:0] l1,
                                                    input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic do_reset();
    reset = 1'b1; req = '0; clockinh = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] len;
    logic                 inh;
    logic [NREQ-1:0]      g;
    logic                 b;
    logic [SIZE-1:0]      c;
    logic [NREQ-1:0]      d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [31:0] l,
                              input logic inh, input logic [3:0] g, input logic b,
                              input logic [7:0] c, input logic [3:0] d);
    vec_t v;
    v.rst = rst; v.req = r; v.len = l; v.inh = inh;
    v.g = g; v.b = b; v.c = c; v.d = d;
    return v;
  endfunction

  initial begin
    logic [31:0] l3;
    logic [31:0] l2;
    int order[5];
    int n;
    int last_c;
    int saw_done;
    checks = 0; errors = 0;
    reset = 1'b1; req = '0; len = '0; clockinh = 1'b0;

    // Single requester, len=3, held past its first done to observe spacing.
    l3 = pack_len(8'd3, 8'd0, 8'd0, 8'd0);
    tbl.push_back(mk(1, 4'b0000, l3, 0, 4'b0000, 0, 8'd0, 4'b0000)); // reset state
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0001, 1, 8'd0, 4'b0000)); // E0
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0001, 1, 8'd1, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0001, 1, 8'd2, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0000, 0, 8'd0, 4'b0001)); // DONE
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0000, 0, 8'd0, 4'b0000)); // IDLE gap
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0001, 1, 8'd0, 4'b0000)); // E0+5
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0001, 1, 8'd1, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0001, 1, 8'd2, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, l3, 0, 4'b0000, 0, 8'd0, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, l3, 0, 4'b0000, 0, 8'd0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, l3, 0, 4'b0000, 0, 8'd0, 4'b0000)); // stays idle

    // All four requesting with len=2: order 0,1,2,3,0 at 4-cycle spacing.
    l2 = pack_len(8'd2, 8'd2, 8'd2, 8'd2);
    order = '{0, 1, 2, 3, 0};
    tbl.push_back(mk(1, 4'b1111, l2, 0, 4'b0000, 0, 8'd0, 4'b0000));
    for (int j = 0; j < 5; j++) begin
      logic [3:0] oh;
      oh = 4'b0001 << order[j];
      tbl.push_back(mk(0, 4'b1111, l2, 0, oh,      1, 8'd0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, l2, 0, oh,      1, 8'd1, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, l2, 0, 4'b0000, 0, 8'd0, oh));
      tbl.push_back(mk(0, 4'b1111, l2, 0, 4'b0000, 0, 8'd0, 4'b0000));
    end

    foreach (tbl[i]) begin
      reset = tbl[i].rst; req = tbl[i].req; len = tbl[i].len; clockinh = tbl[i].inh;
      tick();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].c));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].d));
      chk($sformatf("v%0d_aborted", i), 32'(aborted), 32'd0);
    end

    // ---- len=0: full 256-tick interval, count wraps 255 -> done ----
    do_reset();
    len = pack_len(8'd0, 8'd0, 8'd0, 8'd0);
    req = 4'b0001;
    tick();
    n = 0; last_c = -1; saw_done = 0;
    for (int k = 0; k < 300; k++) begin
      if (grant != 4'b0001) break;
      if (count != 8'(n)) begin
        chk("wrap_count_seq", 32'(count), 32'(n));
      end
      last_c = int'(count);
      n++;
      tick();
    end
    chk("wrap_grant_cycles", 32'(n), 32'd256);
    chk("wrap_last_count", 32'(last_c), 32'd255);
    chk("wrap_done", 32'(done), 32'b0001);
    req = 4'b0000;
    tick();
    chk("wrap_done_once", 32'(done), 32'd0);

    // ---- len=4 with clockinh held 3 cycles at count=1 ----
    do_reset();
    len = pack_len(8'd4, 8'd0, 8'd0, 8'd0);
    req = 4'b0001;
    tick(); chk("inh_c0", 32'(count), 32'd0);
    tick(); chk("inh_c1", 32'(count), 32'd1);
    clockinh = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("inh_hold%0d", k), 32'(count), 32'd1);
      chk($sformatf("inh_hold_grant%0d", k), 32'(grant), 32'b0001);
    end
    clockinh = 1'b0;
    tick(); chk("inh_c2", 32'(count), 32'd2);
    tick(); chk("inh_c3", 32'(count), 32'd3);
    chk("inh_no_early_done", 32'(done), 32'd0);
    tick(); chk("inh_done", 32'(done), 32'b0001);
    chk("inh_grant_off", 32'(grant), 32'd0);
    req = 4'b0000;
    tick();

    // ---- reset during RUN: no done, next request served from index 0 ----
    do_reset();
    len = pack_len(8'd5, 8'd5, 8'd5, 8'd5);
    req = 4'b0010;
    tick(); chk("rst_run_grant", 32'(grant), 32'b0010);
    tick(); chk("rst_run_c1", 32'(count), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_run_outs", 32'({grant, busy, count, done, aborted}), 32'd0);
    reset = 1'b0;
    req = 4'b0011;
    tick();
    chk("rst_run_nodone", 32'(done), 32'd0);
    chk("rst_run_from0", 32'(grant), 32'b0001);

`ifdef COUNTER_SCHED_ABORT_EN
    // ---- abort: req1 dropped at count=2 of a len=5 job ----
    do_reset();
    len = pack_len(8'd5, 8'd5, 8'd5, 8'd5);
    req = 4'b0010;
    tick(); chk("ab_grant", 32'(grant), 32'b0010);
    tick();
    tick(); chk("ab_c2", 32'(count), 32'd2);
    req = 4'b1100;
    tick();
    chk("ab_pulse", 32'(aborted), 32'd1);
    chk("ab_nodone", 32'(done), 32'd0);
    chk("ab_outs", 32'({grant, busy, count}), 32'd0);
    tick();
    chk("ab_pulse_end", 32'(aborted), 32'd0);
    chk("ab_next", 32'(grant), 32'b0100);
    chk("ab_nodone2", 32'(done), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
